// File: rtl/clk_en_gen.sv
// Fractional clock-enable generator: NUM_CH phase accumulators on one refclk,
// all re-phased together after reset or any config write, then gated by a lock timer.

module clk_en_ch #(
  parameter int               ACC_W   = 16,
  parameter logic [ACC_W-1:0] RST_INC = '0,
  parameter logic [ACC_W-1:0] RST_MOD = '0
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             run,
  input  logic             we,
  input  logic [ACC_W-1:0] wr_inc,
  input  logic [ACC_W-1:0] wr_mod,
  output logic             ce,
  output logic             err
);
  logic [ACC_W-1:0] inc_q, mod_q, acc_q;
  logic [ACC_W:0]   sum, wrap;

  assign err  = (mod_q == '0) || (inc_q > mod_q);
  assign sum  = {1'b0, acc_q} + {1'b0, inc_q};
  assign wrap = sum - {1'b0, mod_q};

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      inc_q <= RST_INC;
      mod_q <= RST_MOD;
      acc_q <= '0;
      ce    <= 1'b0;
    end else begin
      if (we) begin
        inc_q <= wr_inc;
        mod_q <= wr_mod;
      end
      if (!run || err) begin
        acc_q <= '0;
        ce    <= 1'b0;
      end else if (sum >= {1'b0, mod_q}) begin
        // acc < mod and inc <= mod keep the wrapped value below mod
        acc_q <= wrap[ACC_W-1:0];
        ce    <= 1'b1;
      end else begin
        acc_q <= sum[ACC_W-1:0];
        ce    <= 1'b0;
      end
    end
  end
endmodule

module clk_en_gen #(
  parameter int                        NUM_CH      = 2,
  parameter int                        ACC_W       = 16,
  parameter int                        LOCK_CYCLES = 16,
  parameter logic [NUM_CH*ACC_W-1:0]   DEF_INC     = {16'd1, 16'd6},
  parameter logic [NUM_CH*ACC_W-1:0]   DEF_MOD     = {16'd50, 16'd25},
  localparam int                       CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_mod,
  output logic [NUM_CH-1:0] ce,
  output logic              locked,
  output logic [NUM_CH-1:0] cfg_err
);
  localparam int               CNT_W = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic {COUNT, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             wr_hit, run;

  // Out-of-range channel writes are dropped before they can touch anything
  assign wr_hit = cfg_we && (32'(cfg_ch) < NUM_CH);
  assign run    = (state_q == LOCKED) && !wr_hit;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) state_q <= COUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (wr_hit)                                state_d = COUNT;
    else if (state_q == COUNT && cnt_q == LAST) state_d = LOCKED;
  end

  always_comb begin
    locked = (state_q == LOCKED);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst)                                             cnt_q <= '0;
    else if (wr_hit || state_q == LOCKED || cnt_q == LAST) cnt_q <= '0;
    else                                                 cnt_q <= cnt_q + 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_en_ch #(
      .ACC_W   (ACC_W),
      .RST_INC (DEF_INC[i*ACC_W +: ACC_W]),
      .RST_MOD (DEF_MOD[i*ACC_W +: ACC_W])
    ) u_ch (
      .refclk (refclk),
      .rst    (rst),
      .run    (run),
      .we     (wr_hit && (32'(cfg_ch) == i)),
      .wr_inc (cfg_inc),
      .wr_mod (cfg_mod),
      .ce     (ce[i]),
      .err    (cfg_err[i])
    );
  end
endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: lock timing, pulse rates, config writes, async reset.
// A 3-channel instance exercises the out-of-range channel write.

module tb_clk_en_gen;
  logic        refclk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [0:0]  cfg_ch;
  logic [15:0] cfg_inc, cfg_mod;
  logic [1:0]  ce, cfg_err;
  logic        locked;

  logic        cfg_we3;
  logic [1:0]  cfg_ch3;
  logic [15:0] cfg_inc3, cfg_mod3;
  logic [2:0]  ce3, cfg_err3;
  logic        locked3;

  int nchk = 0;
  int nerr = 0;

  always #5 refclk = ~refclk;

  clk_en_gen u_dut (
    .refclk (refclk), .rst (rst), .cfg_we (cfg_we), .cfg_ch (cfg_ch),
    .cfg_inc (cfg_inc), .cfg_mod (cfg_mod), .ce (ce), .locked (locked), .cfg_err (cfg_err)
  );

  clk_en_gen #(
    .NUM_CH  (3),
    .DEF_INC ({16'd1, 16'd1, 16'd6}),
    .DEF_MOD ({16'd4, 16'd50, 16'd25})
  ) u_dut3 (
    .refclk (refclk), .rst (rst), .cfg_we (cfg_we3), .cfg_ch (cfg_ch3),
    .cfg_inc (cfg_inc3), .cfg_mod (cfg_mod3), .ce (ce3), .locked (locked3), .cfg_err (cfg_err3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic wr(input logic ch, input logic [15:0] inc, input logic [15:0] md);
    cfg_we = 1'b1; cfg_ch = ch; cfg_inc = inc; cfg_mod = md;
    tick();
    cfg_we = 1'b0;
  endtask

  // Expects locked low on edge 15 and high (ce still 0) on edge 16 after the start point
  task automatic lock_wait(input string tag);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) chk({tag, "_lock15"}, locked, 0);
      if (k == 16) begin
        chk({tag, "_lock16"}, locked, 1);
        chk({tag, "_ce16"}, ce, 0);
      end
    end
  endtask

  // Default rates over 50 LOCKED edges: ch0 6/25 first at 5, ch1 1/50 at 50
  task automatic chk_defaults(input string tag, input bit do3);
    int f0, f1, n0_25, n0, n1, lo3, n32;
    f0 = 0; f1 = 0; n0_25 = 0; n0 = 0; n1 = 0; lo3 = 0; n32 = 0;
    for (int k = 1; k <= 50; k++) begin
      if (do3 && k == 10) begin
        cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_inc3 = 16'd1; cfg_mod3 = 16'd1;
      end
      tick();
      cfg_we3 = 1'b0;
      if (ce[0]) begin
        n0++;
        if (k <= 25) n0_25++;
        if (f0 == 0) f0 = k;
      end
      if (ce[1]) begin
        n1++;
        if (f1 == 0) f1 = k;
      end
      if (!locked3) lo3++;
      if (ce3[2]) n32++;
    end
    chk({tag, "_first0"}, f0, 5);
    chk({tag, "_n0_25"}, n0_25, 6);
    chk({tag, "_n0_50"}, n0, 12);
    chk({tag, "_n1"}, n1, 1);
    chk({tag, "_first1"}, f1, 50);
    if (do3) begin
      chk("ign_locked_low", lo3, 0);
      chk("ign_ch2_pulses", n32, 12);
      chk("ign_err", cfg_err3, 0);
    end
  endtask

  initial begin
    int n0, n1, nz, f0;
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_mod = '0;
    cfg_we3 = 1'b0; cfg_ch3 = '0; cfg_inc3 = '0; cfg_mod3 = '0;
    #3;
    chk("rst_locked", locked, 0);
    chk("rst_ce", ce, 0);
    chk("rst_err", cfg_err, 0);
    tick(); tick();
    rst = 1'b0;

    lock_wait("init");
    chk_defaults("def", 1'b1);

    // Full-rate channel: silent through relock, then every cycle
    wr(1'b0, 16'd3, 16'd3);
    chk("w33_locked", locked, 0);
    chk("w33_ce", ce, 0);
    nz = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (ce != 0) nz++;
      if (k == 16) chk("w33_lock16", locked, 1);
    end
    chk("w33_ce_quiet", nz, 0);
    n0 = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ce[0]) n0++;
    end
    chk("w33_full_rate", n0, 10);
    chk("w33_err", cfg_err, 0);

    // Invalid ch1 (inc > mod)
    wr(1'b1, 16'd5, 16'd4);
    chk("inv_err", cfg_err, 2);
    lock_wait("inv");
    n0 = 0; n1 = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (ce[0]) n0++;
      if (ce[1]) n1++;
    end
    chk("inv_n0", n0, 30);
    chk("inv_n1", n1, 0);

    // Back-to-back writes; inc=0 is valid but silent
    wr(1'b0, 16'd1, 16'd2);
    wr(1'b1, 16'd0, 16'd7);
    wr(1'b0, 16'd1, 16'd4);
    chk("b2b_err", cfg_err, 0);
    lock_wait("b2b");

    // Write landing on the edge the counter hits its last value
    wr(1'b0, 16'd1, 16'd4);
    for (int k = 1; k <= 15; k++) tick();
    chk("race_pre", locked, 0);
    wr(1'b0, 16'd1, 16'd4);
    chk("race_locked", locked, 0);
    lock_wait("race");
    n0 = 0; n1 = 0; f0 = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (ce[0]) begin
        n0++;
        if (f0 == 0) f0 = k;
      end
      if (ce[1]) n1++;
    end
    chk("q_first0", f0, 4);
    chk("q_n0", n0, 4);
    chk("q_inc0_n1", n1, 0);

    // Async reset between edges while a write is pending
    wr(1'b0, 16'd2, 16'd2);
    lock_wait("pre_rst");
    tick(); tick();
    chk("pre_rst_ce0", ce[0], 1);
    #2;
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_inc = 16'd5; cfg_mod = 16'd5;
    #1 rst = 1'b1;
    #1;
    chk("arst_ce", ce, 0);
    chk("arst_locked", locked, 0);
    tick();
    cfg_we = 1'b0;
    chk("arst_err", cfg_err, 0);
    rst = 1'b0;
    lock_wait("post_rst");
    chk_defaults("post", 1'b0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
